// File: rtl/ps2_device.sv
// PS/2 device-side link controller (keyboard/mouse end of the cable).
// The device always generates PS2_CLK. It sends bytes from a one-entry holding
// register as 11-bit frames (start, 8 data LSB first, odd parity, stop). When
// the host issues a request-to-send, it clocks in 10 bits (8 data, parity and
// stop) and answers with an ack pulse.
// Both lines are open-collector. Each *_O output is tied low, and each *_T
// output selects release (1) or drive-low (0).
//
// Parameters
//   HALF_CYC  PS/2 clock half-period, in Bus2IP_Clk cycles
//   GAP_CYC   minimum idle time between frames, in Bus2IP_Clk cycles
// Ports
//   Bus2IP_Clk, Bus2IP_Reset   system clock; synchronous active-high reset
//   C_I/C_O/C_T                PS2_CLK sampled / drive value / tri-state enable
//   D_I/D_O/D_T                PS2_D   sampled / drive value / tri-state enable
//   tx_data, tx_valid          byte offered for transmission to the host
//   tx_ready                   holding register is empty
//   rx_data                    last byte received from the host
//   rx_valid, rx_err           one-cycle status pulses for a received frame
module ps2_device #(
    parameter int unsigned HALF_CYC = 4000,
    parameter int unsigned GAP_CYC  = 8000
) (
    input  logic       Bus2IP_Clk,
    input  logic       Bus2IP_Reset,
    input  logic       C_I,
    output logic       C_O,
    output logic       C_T,
    input  logic       D_I,
    output logic       D_O,
    output logic       D_T,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int unsigned CNT_MAX = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, TX_HI, TX_LO, RX_WAIT, RX_LO, RX_HI, ACK, GAP
    } state_e;

    state_e        state_q;
    logic          c_meta_q, c_s_q, d_meta_q, d_s_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_idx_q;
    logic [3:0]    bit_nxt;
    logic          pending_q;
    logic [7:0]    tx_hold_q;
    logic [10:0]   tx_frame;
    logic [8:0]    rx_shift_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q, rx_err_q;
    logic          c_t_q, d_t_q;

    // Frame bits in transmit order, index 0 first on the wire.
    always_comb begin
        tx_frame = {1'b1, ~^tx_hold_q, tx_hold_q, 1'b0};
        bit_nxt  = bit_idx_q + 4'd1;
    end

    // Two-flop synchronizers; they reset to the released (high) line level.
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            c_meta_q <= 1'b1;
            c_s_q    <= 1'b1;
            d_meta_q <= 1'b1;
            d_s_q    <= 1'b1;
        end else begin
            c_meta_q <= C_I;
            c_s_q    <= c_meta_q;
            d_meta_q <= D_I;
            d_s_q    <= d_meta_q;
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            pending_q  <= 1'b0;
            tx_hold_q  <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            c_t_q      <= 1'b1;
            d_t_q      <= 1'b1;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;

            // The holding register accepts in any state. The frame end clears
            // pending only while pending is set, so the two never collide.
            if (tx_valid && !pending_q) begin
                pending_q <= 1'b1;
                tx_hold_q <= tx_data;
            end

            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    c_t_q <= 1'b1;
                    d_t_q <= 1'b1;
                    if (!c_s_q) begin
                        state_q <= RX_WAIT;
                    end else if (pending_q) begin
                        state_q   <= TX_HI;
                        bit_idx_q <= '0;
                        d_t_q     <= tx_frame[0];
                    end
                end

                TX_HI: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!c_s_q) begin
                            // Host inhibit: drop the frame, keep the byte pending.
                            c_t_q   <= 1'b1;
                            d_t_q   <= 1'b1;
                            state_q <= GAP;
                        end else begin
                            c_t_q   <= 1'b0;
                            state_q <= TX_LO;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                TX_LO: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        c_t_q <= 1'b1;
                        if (bit_idx_q == 4'd10) begin
                            pending_q <= 1'b0;
                            d_t_q     <= 1'b1;
                            state_q   <= GAP;
                        end else begin
                            bit_idx_q <= bit_nxt;
                            d_t_q     <= tx_frame[bit_nxt];
                            state_q   <= TX_HI;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                RX_WAIT: begin
                    if (c_s_q) begin
                        if (!d_s_q) begin
                            state_q   <= RX_LO;
                            c_t_q     <= 1'b0;
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end

                RX_LO: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        c_t_q   <= 1'b1;
                        state_q <= RX_HI;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                RX_HI: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 4'd9) begin
                            // Tenth pulse carries the stop bit.
                            if (d_s_q) begin
                                state_q   <= ACK;
                                c_t_q     <= 1'b0;
                                d_t_q     <= 1'b0;
                                bit_idx_q <= '0;
                                rx_data_q <= rx_shift_q[7:0];
                                if (^rx_shift_q) begin
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    rx_err_q <= 1'b1;
                                end
                            end else begin
                                rx_err_q <= 1'b1;
                                state_q  <= GAP;
                            end
                        end else begin
                            // Data arrives LSB first, so shift in from the top.
                            rx_shift_q <= {d_s_q, rx_shift_q[8:1]};
                            bit_idx_q  <= bit_nxt;
                            c_t_q      <= 1'b0;
                            state_q    <= RX_LO;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ACK: begin
                    // bit_idx_q 0 is the low half of the ack pulse, 1 is the high half.
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 4'd0) begin
                            bit_idx_q <= 4'd1;
                            c_t_q     <= 1'b1;
                        end else begin
                            d_t_q   <= 1'b1;
                            state_q <= GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                GAP: begin
                    c_t_q <= 1'b1;
                    d_t_q <= 1'b1;
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign C_O      = 1'b0;
    assign D_O      = 1'b0;
    assign C_T      = c_t_q;
    assign D_T      = d_t_q;
    assign tx_ready = ~pending_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;

endmodule

// File: doc/ps2_device.md
PS2_DEVICE -- requirements
Module: ps2_device

Interface
REQ-001 The block SHALL have parameter HALF_CYC, default 4000, giving the PS/2 clock half-period in Bus2IP_Clk cycles (40 us at 100 MHz).
REQ-002 The block SHALL have parameter GAP_CYC, default 8000, giving the minimum idle cycles between frames.
REQ-003 Bus2IP_Clk  in  1  system clock; the block uses one clock, and all logic is clocked on its rising edge.
REQ-004 Bus2IP_Reset  in  1  reset; it is synchronous and active-high.
REQ-005 C_I  in  1  sampled PS2_CLK line.
REQ-006 C_O  out  1  PS2_CLK drive value; it SHALL be tied to 0 (open-collector).
REQ-007 C_T  out  1  PS2_CLK tri-state enable; 1 releases the line, 0 drives it low.
REQ-008 D_I  in  1  sampled PS2_D line.
REQ-009 D_O  out  1  PS2_D drive value; it SHALL be tied to 0.
REQ-010 D_T  out  1  PS2_D tri-state enable; 1 releases the line, 0 drives it low.
REQ-011 tx_data  in  8  byte to send to the host.
REQ-012 tx_valid  in  1  tx_data is offered.
REQ-013 tx_ready  out  1  holding register is empty; the byte is accepted when tx_valid&tx_ready.
REQ-014 rx_data  out  8  last byte received from the host.
REQ-015 rx_valid  out  1  one-cycle pulse; rx_data is new and valid.
REQ-016 rx_err  out  1  one-cycle pulse on a parity or stop-bit error.

Function
REQ-017 C_I and D_I SHALL pass through 2-FF synchronizers; all decisions SHALL use the synced values (C_s, D_s).
REQ-018 The FSM states SHALL be IDLE, TX_HI, TX_LO, RX_WAIT, RX_LO, RX_HI, ACK and GAP.
REQ-019 Holding register: on accept, tx_ready SHALL go 0 the next cycle and return to 1 only after a completed TX frame.
REQ-020 In IDLE, C_s=0 SHALL transition to RX_WAIT, with priority over a pending TX.
REQ-021 In IDLE, pending TX with C_s=1 SHALL transition to TX_HI with bit index 0.
REQ-022 TX frame = 11 bits, sent in this order:
- start 0;
- data[0..7], LSB first;
- odd parity (set so the nine bits have an odd count of ones);
- stop 1.
REQ-023 TX_HI SHALL release clock and set D_T=bit (0 drives low) for HALF_CYC cycles; TX_LO SHALL drive clock low for HALF_CYC cycles with D held.
REQ-024 At the last cycle of TX_HI, C_s=0 (host inhibit) SHALL abort:
- release both lines;
- keep the byte pending;
- go to GAP.
REQ-025 After the TX_LO of bit 10, the FSM SHALL clear pending, release both lines and go to GAP.
REQ-026 RX_WAIT SHALL hold until C_s=1; then D_s=0 goes to RX_LO (request-to-send), otherwise to IDLE.
REQ-027 RX SHALL generate 10 clock pulses (LO then HI, HALF_CYC each) and sample D_s at the last cycle of each RX_HI:
- pulses 1-8 give data, LSB first;
- pulse 9 gives parity;
- pulse 10 gives stop.
REQ-028 Stop=1 SHALL enter ACK: D_T=0 through one further LO+HI pulse, then release D and go to GAP.
REQ-029 Stop=0 SHALL skip ACK, pulse rx_err and go to GAP.
REQ-030 On ACK entry, rx_data SHALL update and either rx_valid pulses (parity good) or rx_err pulses (parity bad), never both.
REQ-031 GAP SHALL release both lines for GAP_CYC cycles, then return to IDLE.
REQ-032 A tx_valid arriving during any RX or TX state SHALL still be accepted if tx_ready=1.

Reset
REQ-033 Reset SHALL, at any point mid-frame, force:
- state IDLE;
- C_T=D_T=1;
- tx_ready=1, with any pending byte discarded;
- rx_valid=rx_err=0;
- rx_data=0x00;
- counters and synchronizers to idle-high.

Verification (HALF_CYC=4, GAP_CYC=8)
REQ-034 Accept tx_data=0xFA -> PS2_D samples on 11 clock falls read 0,0,1,0,1,1,1,1,1,1,1; each low pulse lasts 4 cycles; tx_ready=1 after GAP.
REQ-035 Host sends RTS then 0xF4 with parity 0 and stop 1 -> rx_data=0xF4, rx_valid high one cycle, PS2_D low during the 11th clock pulse.
REQ-036 Host sends 0xF4 with parity 1 -> rx_err one-cycle pulse, rx_valid stays 0, ACK still driven.
REQ-037 Host holds PS2_CLK low during TX bit 4 -> both lines released, tx_ready stays 0; after release and GAP the frame restarts from the start bit.
REQ-038 Bus2IP_Reset asserted during RX bit 5 -> next cycle C_T=D_T=1, rx_valid=0, tx_ready=1, state IDLE.
REQ-039 tx_valid held continuously during a TX frame -> exactly one byte is accepted per completed frame.
